// File: rtl/ds1302_set_seq.sv
// rtl/ds1302_set_seq.sv - issues the nine-byte DS1302 time-set write sequence through ds1302write
module ds1302_set_seq #(
    parameter int CLK_DIV       = 50,
    parameter int GAP_CYC       = 100,
    parameter int TIMEOUT_EDGES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hour,
    input  logic [7:0] date,
    input  logic [7:0] month,
    input  logic [7:0] day,
    input  logic [7:0] year,
    output logic       wrEn,
    output logic [7:0] wrAddr,
    output logic [7:0] wrData,
    input  logic       wrCe,
    input  logic       wrDone,
    output logic       sclk,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] curIdx
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int EW = $clog2(TIMEOUT_EDGES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [EW-1:0] TO_EDGES = EW'(TIMEOUT_EDGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_n;
    logic [3:0]    idx, idx_n;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [EW-1:0] edge_cnt;
    logic [7:0]    sec_q, min_q, hour_q, date_q, month_q, day_q, year_q;
    logic [7:0]    addr_n, data_n;
    logic          accept, run, rise, timeout;

    assign accept  = start && (state == S_IDLE || state == S_ERR);
    assign run     = (state == S_WAIT) && wrCe;
    assign rise    = run && (div_cnt == DIV_LAST) && !sclk;
    assign timeout = (state == S_WAIT) && (edge_cnt == TO_EDGES);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            S_IDLE, S_ERR: begin
                if (accept) begin
                    state_n = S_ISSUE;
                    idx_n   = 4'd0;
                end
            end
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                // a completion arriving with the last permitted edge still counts as success
                if (wrDone)
                    state_n = S_GAP;
                else if (timeout)
                    state_n = S_ERR;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (idx == 4'd8) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ISSUE;
                        idx_n   = idx + 4'd1;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        addr_n = 8'h00;
        data_n = 8'h00;
        case (idx_n)
            4'd0: begin addr_n = 8'h8E; data_n = 8'h00;    end
            4'd1: begin addr_n = 8'h80; data_n = sec_q;    end
            4'd2: begin addr_n = 8'h82; data_n = min_q;    end
            4'd3: begin addr_n = 8'h84; data_n = hour_q;   end
            4'd4: begin addr_n = 8'h86; data_n = date_q;   end
            4'd5: begin addr_n = 8'h88; data_n = month_q;  end
            4'd6: begin addr_n = 8'h8A; data_n = day_q;    end
            4'd7: begin addr_n = 8'h8C; data_n = year_q;   end
            4'd8: begin addr_n = 8'h8E; data_n = 8'h80;    end
            default: begin addr_n = 8'h00; data_n = 8'h00; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            idx    <= 4'd0;
            wrAddr <= 8'h00;
            wrData <= 8'h00;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state_n == S_ISSUE) begin
                wrAddr <= addr_n;
                wrData <= data_n;
            end
        end
    end

    // clock-halt bit is always cleared so the oscillator runs after the set
    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= 8'h00;
            date_q  <= 8'h00;
            month_q <= 8'h00;
            day_q   <= 8'h00;
            year_q  <= 8'h00;
        end else if (accept) begin
            sec_q   <= sec & 8'h7F;
            min_q   <= min;
            hour_q  <= hour;
            date_q  <= date;
            month_q <= month;
            day_q   <= day;
            year_q  <= year;
        end
    end

    // sclk is dropped on the same edge that leaves WAIT, so it never lingers high
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (run && state_n == S_WAIT) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || state != S_WAIT)
            edge_cnt <= '0;
        else if (rise && edge_cnt != TO_EDGES)
            edge_cnt <= edge_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst || state != S_GAP)
            gap_cnt <= '0;
        else
            gap_cnt <= gap_cnt + 1'b1;
    end

    assign wrEn   = (state == S_ISSUE);
    assign busy   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP) || (state == S_DONE);
    assign done   = (state == S_DONE);
    assign error  = (state == S_ERR);
    assign curIdx = idx;

endmodule

// File: tb/tb_ds1302_set_seq.sv
// tb/tb_ds1302_set_seq.sv - directed bench for ds1302_set_seq with a behavioural write-engine model
module tb_ds1302_set_seq;

    localparam int CLK_DIV       = 4;
    localparam int GAP_CYC       = 10;
    localparam int TIMEOUT_EDGES = 20;
    localparam int DONE_RISES    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sec = 8'h00, min = 8'h00, hour = 8'h00, date = 8'h00;
    logic [7:0] month = 8'h00, day = 8'h00, year = 8'h00;
    logic       wrEn;
    logic [7:0] wrAddr, wrData;
    logic       wrCe = 1'b0;
    logic       wrDone = 1'b0;
    logic       sclk, busy, done, error;
    logic [3:0] curIdx;

    ds1302_set_seq #(
        .CLK_DIV      (CLK_DIV),
        .GAP_CYC      (GAP_CYC),
        .TIMEOUT_EDGES(TIMEOUT_EDGES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sec   (sec),
        .min   (min),
        .hour  (hour),
        .date  (date),
        .month (month),
        .day   (day),
        .year  (year),
        .wrEn  (wrEn),
        .wrAddr(wrAddr),
        .wrData(wrData),
        .wrCe  (wrCe),
        .wrDone(wrDone),
        .sclk  (sclk),
        .busy  (busy),
        .done  (done),
        .error (error),
        .curIdx(curIdx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_pairs [9] = '{16'h8E00, 16'h8005, 16'h8230, 16'h8412, 16'h8615,
                                   16'h8806, 16'h8A03, 16'h8C24, 16'h8E80};

    // engine model and monitor state
    logic [15:0] log_q [$];
    int  cyc = 0, done_cnt = 0;
    int  hang_idx = -1, ce_idx = -1, ce_delay = 0;
    bit  active = 0, sclk_q = 0;
    int  rises = 0, ce_wait = 0, ce_cyc = 0, last_rise = -1, last_done = -1, last_idx = 0;
    int  gap_bad = 0, period_bad = 0, gate_bad = 0, first_rise_gap = -1, done_lat = -1;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            wrDone = 1'b0;
            if (!rst) begin
                active    = 0;
                wrCe      = 1'b0;
                last_done = -1;
            end else begin
                if (!wrCe && sclk) gate_bad++;
                if (done) begin
                    done_cnt++;
                    done_lat  = (last_done >= 0) ? cyc - last_done : -1;
                    last_done = -1;
                end
                if (wrEn) begin
                    log_q.push_back({wrAddr, wrData});
                    if (last_done >= 0 && cyc - last_done != GAP_CYC + 1) gap_bad++;
                    last_done = -1;
                    active    = 1;
                    rises     = 0;
                    last_rise = -1;
                    last_idx  = int'(curIdx);
                    if (last_idx == ce_idx) begin
                        wrCe    = 1'b0;
                        ce_wait = ce_delay;
                    end else begin
                        wrCe = 1'b1;
                    end
                end else if (active) begin
                    if (sclk && !sclk_q) begin
                        rises++;
                        if (last_rise >= 0 && cyc - last_rise != 2 * CLK_DIV) period_bad++;
                        if (last_rise < 0 && last_idx == ce_idx) first_rise_gap = cyc - ce_cyc;
                        last_rise = cyc;
                    end
                    if (!wrCe) begin
                        if (ce_wait > 0) ce_wait--;
                        else begin
                            wrCe   = 1'b1;
                            ce_cyc = cyc;
                        end
                    end else if (rises == DONE_RISES && last_idx != hang_idx) begin
                        wrDone    = 1'b1;
                        wrCe      = 1'b0;
                        active    = 0;
                        last_done = cyc;
                    end
                end
            end
            sclk_q = sclk;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < 8000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_in_done"}, busy, 1);
        tick();
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, log_q.size(), 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("%s_pair%0d", tag, i), (log_q.size() > i) ? log_q[i] : 16'hDEAD, exp_pairs[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrEn"}, wrEn, 0);
        check({tag, "_wrAddr"}, wrAddr, 8'h00);
        check({tag, "_wrData"}, wrData, 8'h00);
        check({tag, "_sclk"}, sclk, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_curIdx"}, curIdx, 4'd0);
    endtask

    initial begin
        int n;
        int base;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        tick(2);

        // full sequence, with sec changed right after start
        sec = 8'h85; min = 8'h30; hour = 8'h12; date = 8'h15;
        month = 8'h06; day = 8'h03; year = 8'h24;
        log_q.delete();
        pulse_start();
        sec = 8'h59;
        check("issue_wrEn", wrEn, 1);
        check("issue_wrAddr", wrAddr, 8'h8E);
        check("issue_wrData", wrData, 8'h00);
        check("issue_busy", busy, 1);
        wait_done("full");
        check_log("full");
        check("full_done_latency", done_lat, GAP_CYC + 1);
        check("full_gap_spacing", gap_bad, 0);
        check("full_sclk_period", period_bad, 0);
        sec = 8'h85;

        // start during WAIT of index 2 is ignored
        log_q.delete();
        base = done_cnt;
        pulse_start();
        n = 0;
        while (log_q.size() < 3 && n < 3000) begin tick(); n++; end
        tick(3);
        check("busy_idx", curIdx, 4'd2);
        pulse_start();
        wait_done("busy_start");
        tick(30);
        check("busy_start_done_count", done_cnt - base, 1);
        check_log("busy_start");

        // engine never completes index 3
        hang_idx = 3;
        log_q.delete();
        pulse_start();
        n = 0;
        while (!error && n < 5000) begin tick(); n++; end
        check("to_error", error, 1);
        check("to_curIdx", curIdx, 4'd3);
        check("to_sclk", sclk, 0);
        check("to_busy", busy, 0);
        check("to_rises", rises, TIMEOUT_EDGES);
        check("to_wrEn_count", log_q.size(), 4);
        tick(60);
        check("to_wrEn_after", log_q.size(), 4);
        check("to_error_sticky", error, 1);
        check("to_curIdx_frozen", curIdx, 4'd3);
        check("to_sclk_after", sclk, 0);
        hang_idx = -1;
        log_q.delete();
        pulse_start();
        check("restart_error", error, 0);
        check("restart_wrEn", wrEn, 1);
        check("restart_wrAddr", wrAddr, 8'h8E);
        check("restart_wrData", wrData, 8'h00);
        check("restart_curIdx", curIdx, 4'd0);
        wait_done("restart");
        check_log("restart");

        // wrCe held low in WAIT of index 4 well past the timeout edge count in clk cycles
        ce_idx   = 4;
        ce_delay = 200;
        gate_bad = 0;
        gap_bad  = 0;
        log_q.delete();
        pulse_start();
        wait_done("gate");
        check_log("gate");
        check("gate_sclk_low", gate_bad, 0);
        check("gate_first_rise", first_rise_gap, CLK_DIV);
        check("gate_gap_spacing", gap_bad, 0);
        check("gate_sclk_period", period_bad, 0);
        ce_idx = -1;

        // reset during WAIT of index 5 while sclk is high
        log_q.delete();
        pulse_start();
        n = 0;
        while (!(log_q.size() == 6 && sclk) && n < 5000) begin tick(); n++; end
        check("midrst_sclk_high", sclk, 1);
        rst = 1'b0;
        tick();
        check_reset_outputs("midrst");
        rst = 1'b1;
        tick(2);
        log_q.delete();
        pulse_start();
        check("midrst_restart_wrEn", wrEn, 1);
        check("midrst_restart_curIdx", curIdx, 4'd0);
        check("midrst_restart_wrAddr", wrAddr, 8'h8E);
        wait_done("midrst");
        check_log("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
